// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: filters resolved branches, queues BTB updates,
// and runs a set-by-set invalidation sweep after reset or flush.
module btb_update_ctrl #(
   parameter int SETS       = 16,
   parameter int SET_BITS   = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                res_valid,
   input  logic [31:0]         res_pc,
   input  logic                res_taken,
   input  logic [31:0]         res_target,
   input  logic                res_pred_hit,
   input  logic [31:0]         res_pred_target,
   input  logic                flush_req,
   output logic                res_ready,
   output logic                btb_update_en,
   output logic [31:0]         btb_update_pc,
   output logic [31:0]         btb_update_target,
   output logic                btb_inval_en,
   output logic [SET_BITS-1:0] btb_inval_set,
   output logic                mispredict,
   output logic                busy,
   output logic [CNT_W-1:0]    drop_cnt
);

   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic {
      ST_SWEEP = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [SET_BITS-1:0] r_idx;
   logic [SET_BITS-1:0] w_idx_nxt;

   logic [31:0]         r_pc  [FIFO_DEPTH];
   logic [31:0]         r_tgt [FIFO_DEPTH];
   logic [PW-1:0]       r_wr;
   logic [PW-1:0]       r_rd;
   logic [PW:0]         r_cnt;
   logic [CNT_W-1:0]    r_drop;
   logic                r_mis;

   logic w_tgt_diff;
   logic w_need;
   logic w_mis;
   logic w_full;
   logic w_empty;
   logic w_run;
   logic w_push;
   logic w_drop;
   logic w_pop;

   assign w_tgt_diff = res_pred_target != res_target;
   assign w_need     = res_valid & res_taken & (!res_pred_hit | w_tgt_diff);
   assign w_mis      = res_valid & ((res_taken != res_pred_hit) |
                       (res_taken & res_pred_hit & w_tgt_diff));

   assign w_full  = r_cnt == (PW+1)'(FIFO_DEPTH);
   assign w_empty = r_cnt == '0;
   assign w_run   = r_state == ST_RUN;

   // A flush discards the same-cycle push outright; it is not a drop.
   assign w_push = w_need & !w_full & !flush_req;
   assign w_drop = w_need & w_full & !flush_req;
   assign w_pop  = w_run & !w_empty & !flush_req;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      unique case (r_state)
         ST_SWEEP: begin
            if (flush_req) begin
               w_idx_nxt = '0;
            end else if (r_idx == SET_BITS'(SETS - 1)) begin
               w_state_nxt = ST_RUN;
               w_idx_nxt   = '0;
            end else begin
               w_idx_nxt = r_idx + SET_BITS'(1);
            end
         end
         ST_RUN: begin
            if (flush_req) begin
               w_state_nxt = ST_SWEEP;
               w_idx_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = ST_SWEEP;
            w_idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_SWEEP;
         r_idx   <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_cnt   <= '0;
         r_drop  <= '0;
         r_mis   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_mis   <= w_mis;
         if (flush_req) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
         end else begin
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
            if (w_push && !w_pop)
               r_cnt <= r_cnt + (PW+1)'(1);
            else if (w_pop && !w_push)
               r_cnt <= r_cnt - (PW+1)'(1);
         end
         if (w_drop && (r_drop != '1))
            r_drop <= r_drop + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc[r_wr]  <= res_pc;
         r_tgt[r_wr] <= res_target;
      end
   end

   assign res_ready         = !w_full;
   assign btb_update_en     = w_pop;
   assign btb_update_pc     = r_pc[r_rd];
   assign btb_update_target = r_tgt[r_rd];
   assign btb_inval_en      = !w_run;
   assign btb_inval_set     = w_run ? '0 : r_idx;
   assign busy              = !w_run;
   assign mispredict        = r_mis;
   assign drop_cnt          = r_drop;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: expected BTB writes are queued
// by the stimulus and consumed by a negedge monitor.
module tb_btb_update_ctrl;

   localparam int SB = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          res_valid;
   logic [31:0]   res_pc;
   logic          res_taken;
   logic [31:0]   res_target;
   logic          res_pred_hit;
   logic [31:0]   res_pred_target;
   logic          flush_req;
   logic          res_ready;
   logic          btb_update_en;
   logic [31:0]   btb_update_pc;
   logic [31:0]   btb_update_target;
   logic          btb_inval_en;
   logic [SB-1:0] btb_inval_set;
   logic          mispredict;
   logic          busy;
   logic [CW-1:0] drop_cnt;

   int checks = 0;
   int errors = 0;
   logic [63:0] sb[$];

   btb_update_ctrl #(
      .SETS(16), .SET_BITS(SB), .FIFO_DEPTH(4), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .res_valid(res_valid), .res_pc(res_pc),
      .res_taken(res_taken), .res_target(res_target),
      .res_pred_hit(res_pred_hit),
      .res_pred_target(res_pred_target),
      .flush_req(flush_req), .res_ready(res_ready),
      .btb_update_en(btb_update_en),
      .btb_update_pc(btb_update_pc),
      .btb_update_target(btb_update_target),
      .btb_inval_en(btb_inval_en),
      .btb_inval_set(btb_inval_set),
      .mispredict(mispredict), .busy(busy),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", n, a, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic br(input logic v, input logic [31:0] pc,
                     input logic tk, input logic [31:0] tgt,
                     input logic hit, input logic [31:0] ptgt);
      res_valid       = v;
      res_pc          = pc;
      res_taken       = tk;
      res_target      = tgt;
      res_pred_hit    = hit;
      res_pred_target = ptgt;
   endtask

   // Monitor: every BTB write must match the oldest expected entry.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         chk("excl", 32'(btb_update_en & btb_inval_en), 32'd0);
         if (btb_update_en) begin
            if (sb.size() == 0) begin
               chk("unexp_upd", 32'd1, 32'd0);
            end else begin
               logic [63:0] x;
               x = sb.pop_front();
               chk("upd_pc", btb_update_pc, x[63:32]);
               chk("upd_tgt", btb_update_target, x[31:0]);
            end
         end
      end
   end

   task automatic wait_run(input string n);
      int k;
      k = 0;
      @(negedge clk);
      while (busy && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk(n, 32'(busy), 32'd0);
   endtask

   initial begin
      reset_n   = 1'b0;
      flush_req = 1'b0;
      br(0, 0, 0, 0, 0, 0);
      step();
      reset_n = 1'b1;

      // reset sweep: 16 sets in order
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("sw_inv", 32'(btb_inval_en), 32'd1);
         chk("sw_set", 32'(btb_inval_set), 32'(i));
         chk("sw_busy", 32'(busy), 32'd1);
         chk("sw_rdy", 32'(res_ready), 32'd1);
         if (i == 0) begin
            chk("rst_mis", 32'(mispredict), 32'd0);
            chk("rst_drop", 32'(drop_cnt), 32'd0);
         end
      end
      @(negedge clk);
      chk("run_inv", 32'(btb_inval_en), 32'd0);
      chk("run_busy", 32'(busy), 32'd0);
      chk("run_set", 32'(btb_inval_set), 32'd0);

      // taken, BTB miss -> update + mispredict
      step();
      br(1, 32'h100, 1, 32'h240, 0, 0);
      sb.push_back({32'h100, 32'h240});
      step();
      br(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("mis_miss", 32'(mispredict), 32'd1);
      @(negedge clk);
      chk("mis_clr", 32'(mispredict), 32'd0);

      // correct prediction
      step();
      br(1, 32'h40, 1, 32'h80, 1, 32'h80);
      step();
      br(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("mis_ok", 32'(mispredict), 32'd0);

      // not taken but predicted hit
      step();
      br(1, 32'h44, 0, 32'h0, 1, 32'h80);
      step();
      br(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("mis_nt", 32'(mispredict), 32'd1);

      // wrong target on hit -> update + mispredict
      step();
      br(1, 32'h48, 1, 32'h300, 1, 32'h304);
      sb.push_back({32'h48, 32'h300});
      step();
      br(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("mis_tgt", 32'(mispredict), 32'd1);
      repeat (3) @(negedge clk);
      chk("drain1", 32'(sb.size()), 32'd0);

      // overflow during sweep: 6 pushes, 4 kept
      step();
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         br(1, 32'h1000 + 32'(i * 4), 1, 32'h2000 + 32'(i * 16), 0, 0);
         if (i < 4) sb.push_back({32'h1000 + 32'(i * 4),
                                  32'h2000 + 32'(i * 16)});
         @(negedge clk);
         chk("ovf_rdy", 32'(res_ready), (i < 4) ? 32'd1 : 32'd0);
         step();
      end
      br(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("ovf_drop", 32'(drop_cnt), 32'd2);
      wait_run("ovf_run");
      repeat (5) @(negedge clk);
      chk("drain2", 32'(sb.size()), 32'd0);

      // flush with pending entries and a simultaneous push
      step();
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         br(1, 32'h500 + 32'(i * 4), 1, 32'h600 + 32'(i * 4), 0, 0);
         sb.push_back({32'h500 + 32'(i * 4), 32'h600 + 32'(i * 4)});
         step();
      end
      br(0, 0, 0, 0, 0, 0);
      wait_run("fl_run");
      step();
      chk("fl_pend", 32'(sb.size()), 32'd3);
      sb.delete();
      flush_req = 1'b1;
      br(1, 32'h700, 1, 32'h704, 0, 0);
      step();
      flush_req = 1'b0;
      br(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("fl_inv", 32'(btb_inval_en), 32'd1);
         chk("fl_set", 32'(btb_inval_set), 32'(i));
      end
      @(negedge clk);
      chk("fl_done", 32'(busy), 32'd0);
      chk("fl_drop", 32'(drop_cnt), 32'd2);
      repeat (4) @(negedge clk);

      // drive drop_cnt into saturation, never leaving the sweep
      for (int l = 0; l < 24; l++) begin
         step();
         flush_req = 1'b1;
         br(1, 32'h900, 1, 32'h904, 0, 0);
         step();
         flush_req = 1'b0;
         repeat (14) step();
         if (l == 0) chk("sat_step", 32'(drop_cnt), 32'd12);
      end
      step();
      br(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) sb.push_back({32'h900, 32'h904});
      @(negedge clk);
      chk("sat_max", 32'(drop_cnt), 32'hFF);
      wait_run("sat_run");
      repeat (6) @(negedge clk);
      chk("drain3", 32'(sb.size()), 32'd0);
      chk("sat_hold", 32'(drop_cnt), 32'hFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
